// File: rtl/restador_pkg.sv
// restador_pkg: default width, operand type and difference/borrow result type for the subtractor
package restador_pkg;
  localparam int RESTADOR_WIDTH = 4;
  typedef logic [RESTADOR_WIDTH-1:0] operand_t;
  typedef struct packed {
    logic     borrow;
    operand_t diff;
  } resta_t;
endpackage

// File: rtl/full_restador.sv
// full_restador: 1-bit full-subtractor cell (a - b - bi -> d, borrow-out bo)
module full_restador (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);
endmodule

// File: rtl/restador_binario_sync.sv
// restador_binario_sync: registered WIDTH-bit ripple subtractor, {Borrow,Resultado} = A - B - Bin, 1-cycle latency
// Ports: clk, rst_n (sync, active-low), in_valid, A, B, Bin in; Resultado, Borrow, out_valid out.
// RESTADOR_SIGNED_OVF_EN adds a registered two's-complement Overflow output.
module restador_binario_sync
  import restador_pkg::*;
#(
  parameter int WIDTH = RESTADOR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Resultado,
  output logic             Borrow,
`ifdef RESTADOR_SIGNED_OVF_EN
  output logic             Overflow,
`endif
  output logic             out_valid
);
  typedef struct packed {
    logic             borrow;
    logic [WIDTH-1:0] diff;
  } res_t;
  logic [WIDTH:0]   bc;
  logic [WIDTH-1:0] dc;
  res_t             r_c, r_d, r_q;
  logic             v_d, v_q;
  assign bc[0] = Bin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_restador u_cell (
      .a (A[i]),
      .b (B[i]),
      .bi(bc[i]),
      .d (dc[i]),
      .bo(bc[i+1])
    );
  end
  assign r_c = '{borrow: bc[WIDTH], diff: dc};
  always_comb begin
    r_d = in_valid ? r_c : r_q;
    v_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
      v_q <= 1'b0;
    end else begin
      r_q <= r_d;
      v_q <= v_d;
    end
  end
  assign Resultado = r_q.diff;
  assign Borrow    = r_q.borrow;
  assign out_valid = v_q;
`ifdef RESTADOR_SIGNED_OVF_EN
  logic o_d, o_q;
  assign o_d = in_valid ? (A[WIDTH-1] ^ B[WIDTH-1]) & (dc[WIDTH-1] ^ A[WIDTH-1]) : o_q;
  always_ff @(posedge clk) begin
    if (!rst_n) o_q <= 1'b0;
    else        o_q <= o_d;
  end
  assign Overflow = o_q;
`endif
endmodule

// File: tb/tb_restador_binario_sync.sv
// tb_restador_binario_sync: scoreboard bench with directed, exhaustive and random stimulus against an arithmetic model
module tb_restador_binario_sync;
  localparam int W = 4;
  typedef struct {
    logic [W-1:0] r;
    logic         b;
    logic         o;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n, in_valid, Bin;
  logic [W-1:0] A, B, Resultado;
  logic         Borrow, out_valid;
`ifdef RESTADOR_SIGNED_OVF_EN
  logic         Overflow;
`endif
  exp_t q[$];
  exp_t last;
  int compared = 0, mismatched = 0;
  bit done = 0;
  always #5 clk = ~clk;
  restador_binario_sync #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .Resultado(Resultado),
    .Borrow   (Borrow),
`ifdef RESTADOR_SIGNED_OVF_EN
    .Overflow (Overflow),
`endif
    .out_valid(out_valid)
  );
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    int d = int'(a) - int'(b) - int'(bi);
    e.b = d < 0;
    e.r = W'(d + (1 << W));
    e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    return e;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input logic rn);
    in_valid = v; A = a; B = b; Bin = bi; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      last = '{r: '0, b: 1'b0, o: 1'b0};
    end else if (v) q.push_back(model(a, b, bi));
    #1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      e = (q.size() != 0) ? q.pop_front() : last;
      last = e;
      chk("Resultado", int'(Resultado), int'(e.r));
      chk("Borrow", int'(Borrow), int'(e.b));
`ifdef RESTADOR_SIGNED_OVF_EN
      chk("Overflow", int'(Overflow), int'(e.o));
`endif
    end
  end
  initial begin
    last = '{r: '0, b: 1'b0, o: 1'b0};
    step(1, 9, 5, 0, 0);
    step(1, 9, 5, 0, 0);
    step(1, 9, 5, 0, 1);
    step(1, 3, 6, 0, 1);
    step(1, 15, 1, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 15, 1, 1);
    repeat (3) step(0, 4'($urandom), 4'($urandom), 1'($urandom), 1);
    step(1, 7, 8, 0, 1);
    step(1, 5, 5, 0, 1);
    step(1, 8, 0, 1, 1);
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        for (int c = 0; c < 2; c++) step(1, W'(a), W'(b), 1'(c), 1);
    step(1, 2, 9, 0, 0);
    step(1, 12, 3, 1, 1);
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(3, 0) != 0), W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom_range(39, 0) != 0));
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    done = 1;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
